// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM stream arbiter.
package dram_arb_pkg;

  localparam int WORDS         = 16;
  localparam int DRAM_WORD_W   = 32;
  localparam int NUM_TAGS_DFLT = 16;
  localparam int TAG_W_DFLT    = $clog2(NUM_TAGS_DFLT);

  typedef logic [WORDS-1:0][DRAM_WORD_W-1:0] burst_t;
  typedef logic [TAG_W_DFLT-1:0]             tag_idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } issue_state_e;

endpackage

// File: rtl/dram_tag_freelist.sv
// DRAM read-tag free list: busy bitmap with lowest-free allocation, a free
// port and an owner table recording which stream each busy tag belongs to.
module dram_tag_freelist
  import dram_arb_pkg::*;
#(
  parameter int NUM_TAGS    = 16,
  parameter int NUM_STREAMS = 4,
  localparam int TAG_W      = $clog2(NUM_TAGS),
  localparam int SW         = $clog2(NUM_STREAMS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_i,
  input  logic [SW-1:0]    alloc_owner_i,
  output logic [TAG_W-1:0] alloc_idx_o,
  output logic             empty_o,
  input  logic             free_i,
  input  logic [TAG_W-1:0] free_idx_i,
  input  logic [TAG_W-1:0] lookup_idx_i,
  output logic             lookup_busy_o,
  output logic [SW-1:0]    lookup_owner_o
);

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [SW-1:0]       owner_q [NUM_TAGS];

  // Lowest free index; a tag freed this cycle still reads busy here, so it
  // cannot be handed out again until the following cycle.
  always_comb begin
    alloc_idx_o = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx_o = TAG_W'(i);
    end
  end

  assign empty_o        = &busy_q;
  assign lookup_busy_o  = busy_q[lookup_idx_i];
  assign lookup_owner_o = owner_q[lookup_idx_i];

  // Next busy map: free and allocate never target the same tag.
  always_comb begin
    busy_d = busy_q;
    if (free_i)  busy_d[free_idx_i]  = 1'b0;
    if (alloc_i) busy_d[alloc_idx_o] = 1'b1;
  end

  // Busy bitmap register; reset releases every tag.
  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Owner table, written at allocation; contents only meaningful while busy.
  always_ff @(posedge clk_i) begin
    if (alloc_i) owner_q[alloc_idx_o] <= alloc_owner_i;
  end

endmodule

// File: rtl/dram_stream_arbiter.sv
// Round-robin arbiter sharing one DRAM command/response port among several
// memory streams. Reads get a tag from the free list; responses are routed
// back to the owning stream through a one-entry response register.
// Optional macro DRAM_ARB_PERF_EN adds saturating grant/stall counters.
module dram_stream_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_STREAMS = 4,
  parameter int NUM_TAGS    = 16,
  parameter int ADDR_W      = 64,
  parameter int WORDS       = dram_arb_pkg::WORDS
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_STREAMS-1:0]             req_valid,
  output logic [NUM_STREAMS-1:0]             req_ready,
  input  logic [NUM_STREAMS*ADDR_W-1:0]      req_addr,
  input  logic [NUM_STREAMS-1:0]             req_isWr,
  input  logic [NUM_STREAMS*WORDS*32-1:0]    req_wdata,
  output logic                               dram_cmd_valid,
  input  logic                               dram_cmd_ready,
  output logic [ADDR_W-1:0]                  dram_cmd_addr,
  output logic                               dram_cmd_isWr,
  output logic [31:0]                        dram_cmd_tag,
  output logic [31:0]                        dram_cmd_streamId,
  output logic [WORDS*32-1:0]                dram_cmd_wdata,
  input  logic                               dram_resp_valid,
  output logic                               dram_resp_ready,
  input  logic [31:0]                        dram_resp_tag,
  input  logic [WORDS*32-1:0]                dram_resp_rdata,
  output logic [NUM_STREAMS-1:0]             resp_valid,
  input  logic [NUM_STREAMS-1:0]             resp_ready,
  output logic [WORDS*32-1:0]                resp_rdata,
`ifdef DRAM_ARB_PERF_EN
  output logic [NUM_STREAMS*32-1:0]          perf_grants,
  output logic [31:0]                        perf_stall,
`endif
  output logic                               tag_err
);

  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int SW    = $clog2(NUM_STREAMS);
  localparam int SW1   = SW + 1;
  localparam int BW    = WORDS * DRAM_WORD_W;

  issue_state_e            state_q;
  logic [SW-1:0]           rr_ptr_q, rr_ptr_d;
  logic                    cmd_valid_q, cmd_isWr_q;
  logic [ADDR_W-1:0]       cmd_addr_q;
  logic [TAG_W-1:0]        cmd_tag_q;
  logic [SW-1:0]           cmd_sid_q;
  logic [BW-1:0]           cmd_wdata_q;

  logic                    rsp_full_q;
  logic [SW-1:0]           rsp_owner_q;
  logic [TAG_W-1:0]        rsp_tag_q;
  logic [BW-1:0]           rsp_rdata_q;
  logic                    tag_err_q;

  logic                    fl_empty, fl_busy, fl_alloc;
  logic [TAG_W-1:0]        fl_alloc_idx;
  logic [SW-1:0]           fl_owner;

  logic [NUM_STREAMS-1:0]  eligible, grant_oh;
  logic                    grant_vld;
  logic [SW-1:0]           grant_idx;
  logic [SW:0]             rr_sum, rr_inc;
  logic                    rsp_drain, rsp_take;
  logic                    unused_tag_hi;

  logic [ADDR_W-1:0]       addr_a  [NUM_STREAMS];
  logic [BW-1:0]           wdata_a [NUM_STREAMS];

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = req_wdata[i*BW +: BW];
  end

  assign unused_tag_hi = ^dram_resp_tag[31:TAG_W];

  // Round-robin pick starting at rr_ptr; tag-starved reads are not eligible,
  // so a pending write can overtake them.
  always_comb begin
    eligible  = req_valid & (req_isWr | {NUM_STREAMS{~fl_empty}});
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      rr_sum = {1'b0, rr_ptr_q} + SW1'(k);
      if (rr_sum >= SW1'(NUM_STREAMS)) rr_sum = rr_sum - SW1'(NUM_STREAMS);
      if (!grant_vld && eligible[rr_sum[SW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = rr_sum[SW-1:0];
      end
    end
    if (state_q != ST_IDLE || reset) grant_vld = 1'b0;
  end

  // Pointer moves to the stream after the winner.
  always_comb begin
    rr_inc   = {1'b0, grant_idx} + SW1'(1);
    rr_ptr_d = (rr_inc == SW1'(NUM_STREAMS)) ? '0 : rr_inc[SW-1:0];
  end

  assign grant_oh  = NUM_STREAMS'(1) << grant_idx;
  assign req_ready = grant_vld ? grant_oh : '0;
  assign fl_alloc  = grant_vld & ~req_isWr[grant_idx];

  // Issue FSM: grant in IDLE, hold the command register in HOLD until taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_isWr_q  <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_tag_q   <= '0;
      cmd_sid_q   <= '0;
      cmd_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            state_q     <= ST_HOLD;
            rr_ptr_q    <= rr_ptr_d;
            cmd_valid_q <= 1'b1;
            cmd_isWr_q  <= req_isWr[grant_idx];
            cmd_addr_q  <= addr_a[grant_idx];
            cmd_wdata_q <= wdata_a[grant_idx];
            cmd_sid_q   <= grant_idx;
            cmd_tag_q   <= req_isWr[grant_idx] ? '0 : fl_alloc_idx;
          end
        end
        ST_HOLD: begin
          if (dram_cmd_ready) begin
            state_q     <= ST_IDLE;
            cmd_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_drain       = rsp_full_q & resp_ready[rsp_owner_q];
  assign dram_resp_ready = ~reset & (~rsp_full_q | rsp_drain);
  assign rsp_take        = dram_resp_valid & dram_resp_ready;

  // Response register: latch known-tag responses, drop unknown ones and flag them.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_full_q  <= 1'b0;
      rsp_owner_q <= '0;
      rsp_tag_q   <= '0;
      rsp_rdata_q <= '0;
      tag_err_q   <= 1'b0;
    end else begin
      if (rsp_take && fl_busy) begin
        rsp_full_q  <= 1'b1;
        rsp_owner_q <= fl_owner;
        rsp_tag_q   <= dram_resp_tag[TAG_W-1:0];
        rsp_rdata_q <= dram_resp_rdata;
      end else if (rsp_drain) begin
        rsp_full_q  <= 1'b0;
      end
      if (rsp_take && !fl_busy) tag_err_q <= 1'b1;
    end
  end

  dram_tag_freelist #(
    .NUM_TAGS    (NUM_TAGS),
    .NUM_STREAMS (NUM_STREAMS)
  ) u_freelist (
    .clk_i          (clock),
    .rst_i          (reset),
    .alloc_i        (fl_alloc),
    .alloc_owner_i  (grant_idx),
    .alloc_idx_o    (fl_alloc_idx),
    .empty_o        (fl_empty),
    .free_i         (rsp_drain),
    .free_idx_i     (rsp_tag_q),
    .lookup_idx_i   (dram_resp_tag[TAG_W-1:0]),
    .lookup_busy_o  (fl_busy),
    .lookup_owner_o (fl_owner)
  );

  assign dram_cmd_valid    = cmd_valid_q;
  assign dram_cmd_addr     = cmd_addr_q;
  assign dram_cmd_isWr     = cmd_isWr_q;
  assign dram_cmd_tag      = 32'(cmd_tag_q);
  assign dram_cmd_streamId = 32'(cmd_sid_q);
  assign dram_cmd_wdata    = cmd_wdata_q;
  assign resp_valid        = rsp_full_q ? (NUM_STREAMS'(1) << rsp_owner_q) : '0;
  assign resp_rdata        = rsp_rdata_q;
  assign tag_err           = tag_err_q;

`ifdef DRAM_ARB_PERF_EN
  logic [31:0] perf_grants_q [NUM_STREAMS];
  logic [31:0] perf_stall_q;

  // Saturating per-stream grant counters and command-stall counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_STREAMS; i++) perf_grants_q[i] <= '0;
      perf_stall_q <= '0;
    end else begin
      if (grant_vld && perf_grants_q[grant_idx] != '1)
        perf_grants_q[grant_idx] <= perf_grants_q[grant_idx] + 32'd1;
      if (cmd_valid_q && !dram_cmd_ready && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_perf
    assign perf_grants[i*32 +: 32] = perf_grants_q[i];
  end
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_dram_stream_arbiter.sv
// Directed bench for dram_stream_arbiter: per-cycle vector table plus a
// hand-written tag-exhaustion sequence.
module tb_dram_stream_arbiter;

  localparam int NS = 4;
  localparam int NT = 16;
  localparam int AW = 64;
  localparam int WD = 16;
  localparam int BW = WD * 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NS-1:0]     req_valid = '0, req_ready, req_isWr = '0;
  logic [NS*AW-1:0]  req_addr;
  logic [NS*BW-1:0]  req_wdata;
  logic              dram_cmd_valid, dram_cmd_ready = 1'b0;
  logic [AW-1:0]     dram_cmd_addr;
  logic              dram_cmd_isWr;
  logic [31:0]       dram_cmd_tag, dram_cmd_streamId;
  logic [BW-1:0]     dram_cmd_wdata;
  logic              dram_resp_valid = 1'b0, dram_resp_ready;
  logic [31:0]       dram_resp_tag = '0;
  logic [BW-1:0]     dram_resp_rdata = '0;
  logic [NS-1:0]     resp_valid, resp_ready = '0;
  logic [BW-1:0]     resp_rdata;
  logic              tag_err;
`ifdef DRAM_ARB_PERF_EN
  logic [NS*32-1:0]  perf_grants;
  logic [31:0]       perf_stall;
`endif

  dram_stream_arbiter #(.NUM_STREAMS(NS), .NUM_TAGS(NT), .ADDR_W(AW), .WORDS(WD)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_isWr          (req_isWr),
    .req_wdata         (req_wdata),
    .dram_cmd_valid    (dram_cmd_valid),
    .dram_cmd_ready    (dram_cmd_ready),
    .dram_cmd_addr     (dram_cmd_addr),
    .dram_cmd_isWr     (dram_cmd_isWr),
    .dram_cmd_tag      (dram_cmd_tag),
    .dram_cmd_streamId (dram_cmd_streamId),
    .dram_cmd_wdata    (dram_cmd_wdata),
    .dram_resp_valid   (dram_resp_valid),
    .dram_resp_ready   (dram_resp_ready),
    .dram_resp_tag     (dram_resp_tag),
    .dram_resp_rdata   (dram_resp_rdata),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
`ifdef DRAM_ARB_PERF_EN
    .perf_grants       (perf_grants),
    .perf_stall        (perf_stall),
`endif
    .tag_err           (tag_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic        cr;
    logic        dv;
    logic [7:0]  dtag;
    logic [31:0] w0;
    logic [3:0]  rrdy;
    logic [3:0]  e_rq;
    logic        e_cv;
    logic [7:0]  e_tag;
    logic [3:0]  e_sid;
    logic [63:0] e_addr;
    logic        e_dr;
    logic [3:0]  e_rv;
    logic [31:0] e_rd0;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t V(logic rst, logic [3:0] rv, logic cr, logic dv, logic [7:0] dtag,
                             logic [31:0] w0, logic [3:0] rrdy, logic [3:0] e_rq, logic e_cv,
                             logic [7:0] e_tag, logic [3:0] e_sid, logic [63:0] e_addr, logic e_dr,
                             logic [3:0] e_rv, logic [31:0] e_rd0, logic e_err);
    vec_t v;
    v.rst = rst; v.rv = rv; v.cr = cr; v.dv = dv; v.dtag = dtag; v.w0 = w0; v.rrdy = rrdy;
    v.e_rq = e_rq; v.e_cv = e_cv; v.e_tag = e_tag; v.e_sid = e_sid; v.e_addr = e_addr;
    v.e_dr = e_dr; v.e_rv = e_rv; v.e_rd0 = e_rd0; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Apply inputs just after the falling edge; outputs are then sampled 1 ns later.
  task automatic drive(input logic rst, input logic [3:0] rv, input logic [3:0] wr, input logic cr,
                       input logic dv, input logic [7:0] dtag, input logic [31:0] w0,
                       input logic [3:0] rrdy);
    @(negedge clock);
    reset           = rst;
    req_valid       = rv;
    req_isWr        = wr;
    dram_cmd_ready  = cr;
    dram_resp_valid = dv;
    dram_resp_tag   = {24'h0, dtag};
    dram_resp_rdata = {{(BW-32){1'b0}}, w0};
    resp_ready      = rrdy;
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] saddr [NS];
    saddr[0] = 64'h0800; saddr[1] = 64'h1000; saddr[2] = 64'h2000; saddr[3] = 64'h3000;
    req_wdata = '0;
    for (int i = 0; i < NS; i++) begin
      req_addr[i*AW +: AW]  = saddr[i];
      req_wdata[i*BW +: 32] = 32'hA0 + i;
    end

    //            rst rv  cr dv tag w0            rrdy  e_rq e_cv tag sid addr     dr rv  rd0           err
    // reset state
    vecs.push_back(V(1, 4'h0, 1, 0, 0, 32'h0,        4'hF, 4'h0, 0, 0, 0, 64'h0,    0, 4'h0, 32'h0,        0));
    // single read, stream 1
    vecs.push_back(V(0, 4'h2, 1, 0, 0, 32'h0,        4'hF, 4'h2, 0, 0, 0, 64'h0,    1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'h0, 1, 0, 0, 32'h0,        4'hF, 4'h0, 1, 0, 1, 64'h1000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'h0, 1, 1, 0, 32'hDEADBEEF, 4'hF, 4'h0, 0, 0, 1, 64'h1000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'h0, 1, 0, 0, 32'h0,        4'hF, 4'h0, 0, 0, 1, 64'h1000, 1, 4'h2, 32'hDEADBEEF, 0));
    vecs.push_back(V(1, 4'h0, 1, 0, 0, 32'h0,        4'hF, 4'h0, 0, 0, 1, 64'h1000, 0, 4'h0, 32'hDEADBEEF, 0));
    // fairness: all four streams request reads continuously
    vecs.push_back(V(0, 4'hF, 1, 0, 0, 32'h0,        4'hF, 4'h1, 0, 0, 0, 64'h0,    1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'hF, 1, 0, 0, 32'h0,        4'hF, 4'h0, 1, 0, 0, 64'h0800, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'hF, 1, 0, 0, 32'h0,        4'hF, 4'h2, 0, 0, 0, 64'h0800, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'hF, 1, 0, 0, 32'h0,        4'hF, 4'h0, 1, 1, 1, 64'h1000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'hF, 1, 0, 0, 32'h0,        4'hF, 4'h4, 0, 1, 1, 64'h1000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'hF, 1, 0, 0, 32'h0,        4'hF, 4'h0, 1, 2, 2, 64'h2000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'hF, 1, 0, 0, 32'h0,        4'hF, 4'h8, 0, 2, 2, 64'h2000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'hF, 1, 0, 0, 32'h0,        4'hF, 4'h0, 1, 3, 3, 64'h3000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'hF, 1, 0, 0, 32'h0,        4'hF, 4'h1, 0, 3, 3, 64'h3000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'h0, 1, 0, 0, 32'h0,        4'hF, 4'h0, 1, 4, 0, 64'h0800, 1, 4'h0, 32'h0,        0));
    // command backpressure: 5 cycles of dram_cmd_ready=0, stream 0 waiting
    vecs.push_back(V(0, 4'h4, 0, 0, 0, 32'h0,        4'hF, 4'h4, 0, 4, 0, 64'h0800, 1, 4'h0, 32'h0,        0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(V(0, 4'h1, 0, 0, 0, 32'h0,      4'hF, 4'h0, 1, 5, 2, 64'h2000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'h1, 1, 0, 0, 32'h0,        4'hF, 4'h0, 1, 5, 2, 64'h2000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'h1, 1, 0, 0, 32'h0,        4'hF, 4'h1, 0, 5, 2, 64'h2000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'h0, 1, 0, 0, 32'h0,        4'hF, 4'h0, 1, 6, 0, 64'h0800, 1, 4'h0, 32'h0,        0));
    // response backpressure on stream 2
    vecs.push_back(V(0, 4'h0, 1, 1, 2, 32'h22222222, 4'hB, 4'h0, 0, 6, 0, 64'h0800, 1, 4'h0, 32'h0,        0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(V(0, 4'h0, 1, 1, 5, 32'h55555555, 4'hB, 4'h0, 0, 6, 0, 64'h0800, 0, 4'h4, 32'h22222222, 0));
    vecs.push_back(V(0, 4'h0, 1, 1, 5, 32'h55555555, 4'hF, 4'h0, 0, 6, 0, 64'h0800, 1, 4'h4, 32'h22222222, 0));
    vecs.push_back(V(0, 4'h0, 1, 0, 0, 32'h0,        4'hF, 4'h0, 0, 6, 0, 64'h0800, 1, 4'h4, 32'h55555555, 0));
    vecs.push_back(V(0, 4'h0, 1, 0, 0, 32'h0,        4'hF, 4'h0, 0, 6, 0, 64'h0800, 1, 4'h0, 32'h55555555, 0));
    // unknown tag 7, then reset in HOLD, then a late response
    vecs.push_back(V(0, 4'h0, 1, 1, 7, 32'h77777777, 4'hF, 4'h0, 0, 6, 0, 64'h0800, 1, 4'h0, 32'h55555555, 0));
    vecs.push_back(V(0, 4'h0, 1, 0, 0, 32'h0,        4'hF, 4'h0, 0, 6, 0, 64'h0800, 1, 4'h0, 32'h55555555, 1));
    vecs.push_back(V(0, 4'h2, 0, 0, 0, 32'h0,        4'hF, 4'h2, 0, 6, 0, 64'h0800, 1, 4'h0, 32'h55555555, 1));
    vecs.push_back(V(1, 4'h0, 0, 0, 0, 32'h0,        4'hF, 4'h0, 1, 2, 1, 64'h1000, 0, 4'h0, 32'h55555555, 1));
    vecs.push_back(V(0, 4'h0, 0, 0, 0, 32'h0,        4'hF, 4'h0, 0, 0, 0, 64'h0,    1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'h8, 1, 0, 0, 32'h0,        4'hF, 4'h8, 0, 0, 0, 64'h0,    1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'h0, 1, 0, 0, 32'h0,        4'hF, 4'h0, 1, 0, 3, 64'h3000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'h0, 1, 1, 1, 32'h11111111, 4'hF, 4'h0, 0, 0, 3, 64'h3000, 1, 4'h0, 32'h0,        0));
    vecs.push_back(V(0, 4'h0, 1, 0, 0, 32'h0,        4'hF, 4'h0, 0, 0, 3, 64'h3000, 1, 4'h0, 32'h0,        1));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.rv, 4'h0, v.cr, v.dv, v.dtag, v.w0, v.rrdy);
      chk($sformatf("v%0d.req_ready", i),       64'(req_ready),         64'(v.e_rq));
      chk($sformatf("v%0d.dram_cmd_valid", i),  64'(dram_cmd_valid),    64'(v.e_cv));
      chk($sformatf("v%0d.dram_cmd_tag", i),    64'(dram_cmd_tag),      64'(v.e_tag));
      chk($sformatf("v%0d.dram_cmd_sid", i),    64'(dram_cmd_streamId), 64'(v.e_sid));
      chk($sformatf("v%0d.dram_cmd_addr", i),   dram_cmd_addr,          v.e_addr);
      chk($sformatf("v%0d.dram_resp_ready", i), 64'(dram_resp_ready),   64'(v.e_dr));
      chk($sformatf("v%0d.resp_valid", i),      64'(resp_valid),        64'(v.e_rv));
      chk($sformatf("v%0d.resp_rdata0", i),     64'(resp_rdata[31:0]),  64'(v.e_rd0));
      chk($sformatf("v%0d.tag_err", i),         64'(tag_err),           64'(v.e_err));
    end

    // Tag exhaustion: 16 reads from stream 0 with no responses returned.
    drive(1, 4'h0, 4'h0, 1, 0, 0, 32'h0, 4'hF);
    for (int t = 0; t < NT; t++) begin
      drive(0, 4'h1, 4'h0, 1, 0, 0, 32'h0, 4'hF);
      chk($sformatf("exh%0d.req_ready", t), 64'(req_ready), 64'h1);
      drive(0, 4'h0, 4'h0, 1, 0, 0, 32'h0, 4'hF);
      chk($sformatf("exh%0d.cmd_valid", t), 64'(dram_cmd_valid), 64'h1);
      chk($sformatf("exh%0d.cmd_tag", t),   64'(dram_cmd_tag),   64'(t));
    end
    // 17th read starved; a write from stream 2 bypasses it with tag 0.
    drive(0, 4'h5, 4'h4, 1, 0, 0, 32'h0, 4'hF);
    chk("exh.bypass_ready", 64'(req_ready), 64'h4);
    drive(0, 4'h1, 4'h4, 1, 0, 0, 32'h0, 4'hF);
    chk("exh.wr_cmd_valid", 64'(dram_cmd_valid),        64'h1);
    chk("exh.wr_tag",       64'(dram_cmd_tag),          64'h0);
    chk("exh.wr_sid",       64'(dram_cmd_streamId),     64'h2);
    chk("exh.wr_isWr",      64'(dram_cmd_isWr),         64'h1);
    chk("exh.wr_addr",      dram_cmd_addr,              64'h2000);
    chk("exh.wr_wdata0",    64'(dram_cmd_wdata[31:0]),  64'hA2);
    drive(0, 4'h1, 4'h0, 1, 0, 0, 32'h0, 4'hF);
    chk("exh.stall_ready",  64'(req_ready), 64'h0);
    drive(0, 4'h1, 4'h0, 1, 1, 8'd9, 32'h99990009, 4'hF);
    chk("exh.stall_ready2", 64'(req_ready), 64'h0);
    chk("exh.resp_ready",   64'(dram_resp_ready), 64'h1);
    drive(0, 4'h1, 4'h0, 1, 0, 0, 32'h0, 4'hF);
    chk("exh.resp_valid",   64'(resp_valid), 64'h1);
    chk("exh.resp_rdata0",  64'(resp_rdata[31:0]), 64'h99990009);
    chk("exh.stall_ready3", 64'(req_ready), 64'h0);
    drive(0, 4'h1, 4'h0, 1, 0, 0, 32'h0, 4'hF);
    chk("exh.retry_ready",  64'(req_ready), 64'h1);
    drive(0, 4'h0, 4'h0, 1, 0, 0, 32'h0, 4'hF);
    chk("exh.retry_valid",  64'(dram_cmd_valid),    64'h1);
    chk("exh.retry_tag",    64'(dram_cmd_tag),      64'd9);
    chk("exh.retry_sid",    64'(dram_cmd_streamId), 64'h0);
    chk("exh.retry_isWr",   64'(dram_cmd_isWr),     64'h0);
    chk("exh.tag_err",      64'(tag_err),           64'h0);

    drive(0, 4'h0, 4'h0, 1, 0, 0, 32'h0, 4'hF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_stream_arbiter.md
Name: dram_stream_arbiter

Overview:
- Shares the single accelerator DRAM command/response port (16x32-bit burst, tag, streamId, isWr) among NUM_STREAMS memory-stream requesters.
- Round-robin arbitrates commands and allocates a DRAM tag per outstanding read.
- Stamps each command with its streamId.
- Routes each returning read response to the owning stream by tag lookup. Sits between the stream load/store units and the top-level io_dram_* port.

Parameters:
NUM_STREAMS, 4, number of requesting streams (2..8)
NUM_TAGS, 16, max outstanding reads; power of two
ADDR_W, 64, byte address width
WORDS, 16, 32-bit words per burst

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
req_valid  in  NUM_STREAMS  per-stream command valid
req_ready  out  NUM_STREAMS  per-stream command accepted
req_addr  in  NUM_STREAMS*ADDR_W  per-stream burst address
req_isWr  in  NUM_STREAMS  1 = write burst
req_wdata  in  NUM_STREAMS*WORDS*32  per-stream write burst
dram_cmd_valid  out  1  command to DRAM valid
dram_cmd_ready  in  1  DRAM accepts command
dram_cmd_addr  out  ADDR_W  command address
dram_cmd_isWr  out  1  write flag
dram_cmd_tag  out  32  allocated tag, zero-extended; 0 for writes
dram_cmd_streamId  out  32  granted stream index, zero-extended
dram_cmd_wdata  out  WORDS*32  write burst
dram_resp_valid  in  1  DRAM read response valid
dram_resp_ready  out  1  arbiter can take response
dram_resp_tag  in  32  response tag; only low log2(NUM_TAGS) bits used
dram_resp_rdata  in  WORDS*32  read burst
resp_valid  out  NUM_STREAMS  one-hot response to owning stream
resp_ready  in  NUM_STREAMS  per-stream response accept
resp_rdata  out  WORDS*32  registered read burst, shared by all streams
tag_err  out  1  sticky; response arrived for a tag not in flight

Behaviour:
- Reset values:
  - req_ready=0, dram_cmd_valid=0, dram_cmd_* data=0, dram_resp_ready=0, resp_valid=0, resp_rdata=0, tag_err=0.
  - All tags free.
  - Round-robin pointer=0.
  - Reset mid-operation discards in-flight tag state; late responses after reset set tag_err.
- Issue stage, 2-state FSM, IDLE / HOLD:
  - IDLE:
    - Pick the first valid stream at or after rr_ptr (wrapping).
    - If it is a read and the free list is empty, it is skipped: writes can bypass a tag-starved read; reads wait.
    - On a grant, pulse req_ready[g]=1 for one cycle and register addr/isWr/wdata/streamId/tag into the command register.
    - Reads pop the lowest free tag; writes use tag 0 and allocate nothing.
    - Set rr_ptr=g+1 mod NUM_STREAMS and go to HOLD.
  - HOLD: dram_cmd_valid=1 and all command fields stable until dram_cmd_ready; in that cycle return to IDLE.
  - Grant-to-dram_cmd_valid latency: 1 cycle. Max throughput: 1 command per 2 cycles.
  - Simultaneous valids: the stream nearest rr_ptr wins. No stream waits more than NUM_STREAMS-1 grants while its command is eligible.
- Tag table: owner[NUM_TAGS] stream index plus busy bit.
  - Allocation happens at grant.
  - Free happens when the response is handed to the stream (resp_valid & resp_ready).
  - A free and an alloc in the same cycle are both honoured. A tag freed this cycle is not reallocated until the next cycle.
- Response stage: a 1-entry register.
  - dram_resp_ready=1 when the register is empty, or is being drained this cycle.
  - On dram_resp_valid & dram_resp_ready with a busy tag, latch rdata and the tag, then assert resp_valid[owner] the next cycle.
  - resp_valid holds until resp_ready[owner].
  - Unknown (non-busy) tag: accept and drop, set tag_err; it clears only on reset.
  - Response latency DRAM→stream: 1 cycle.
- Writes get no response; streams must not expect one.

Optional Feature:
DRAM_ARB_PERF_EN:
- Defined: adds outputs perf_grants (NUM_STREAMS*32, per-stream granted-command count) and perf_stall (32, cycles with dram_cmd_valid & ~dram_cmd_ready).
- Both are saturating counters, cleared by reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dram_arb_pkg: WORDS, DRAM_WORD_W=32, burst_t (WORDS x 32-bit packed), tag_idx_t, issue FSM state enum.
- Sub-module dram_tag_freelist:
  - NUM_TAGS busy bitmap with lowest-free-index alloc, free port, and empty flag.
  - Owner RAM with a lookup port.

Test Plan:
- Single read: stream 1 requests addr 0x1000. Expect dram_cmd_valid next cycle with tag=0, streamId=1. Return rdata word0=0xDEADBEEF on tag 0. Expect resp_valid=4'b0010 one cycle later, resp_rdata[31:0]=0xDEADBEEF, and tag 0 freed.
- Fairness: all 4 streams hold reads continuously with dram_cmd_ready=1. Grant order is 0,1,2,3,0… Tags are 0,1,2,3 in issue order.
- Tag exhaustion: NUM_TAGS=16 reads issued with no responses. The 17th read stalls (req_ready stays 0) while a concurrent write from another stream is granted with tag 0. One response frees its tag, and the stalled read then issues with that tag.
- Backpressure: dram_cmd_ready=0 for 5 cycles. Command fields stay stable; the next grant occurs only after the accept cycle.
- Response backpressure: resp_ready[2]=0 for 3 cycles. resp_valid holds and dram_resp_ready=0 until the drain cycle. A second response is accepted in the drain cycle.
- Bad tag / reset: a response on a never-issued tag 7 sets tag_err=1, which persists. Asserting reset mid-HOLD clears dram_cmd_valid and tag_err the next cycle, and all tags are free.
